frame_proc_ctrl: RTL
====================

FRAME_PROC_CTRL -- requirements
Module: frame_proc_ctrl

Interface
REQ-001 The module SHALL have parameter C_IMG_COLS, default 80, meaning pixels per line.
REQ-002 The module SHALL have parameter C_IMG_ROWS, default 60, meaning lines per frame.
REQ-003 The module SHALL have parameter C_NB_IMG_PXLS, default 13, meaning pixel address width.
REQ-004 The module SHALL have parameter C_MIN_HIST, default 4, meaning minimum column count for a valid detection.
REQ-005 The module SHALL have parameter C_WDOG_CYC, default 1000000, meaning watchdog limit in clk cycles.
REQ-006 The module SHALL have port clk, input, 1 bit, the system clock; all logic is rising-edge.
REQ-007 The module SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-008 The module SHALL have port run, input, 1 bit, a level request for continuous frame processing.
REQ-009 The module SHALL have port cam_frame_done, input, 1 bit, a one-cycle pulse marking a complete frame in the buffer.
REQ-010 The module SHALL have port cam_hold, output, 1 bit, which blocks camera writes to the buffer.
REQ-011 The module SHALL have port proc_addr, output, C_NB_IMG_PXLS bits, the buffer read address.
REQ-012 The module SHALL have ports proc_col (7 bits) and proc_row (6 bits), outputs giving the column and row of proc_addr.
REQ-013 The module SHALL have port proc_en, output, 1 bit, high while a sweep address is valid.
REQ-014 The module SHALL have port hist_in, input, 6 bits, the running column count from the datapath for the column addressed one cycle earlier.
REQ-015 The module SHALL have outputs result_valid (1 bit), result_col (7 bits), result_cnt (6 bits) and result_found (1 bit), plus input result_ready (1 bit).
REQ-016 The module SHALL have outputs frm_drop (1 bit) and wdog_err (1 bit).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_FRM, SWEEP, DRAIN and REPORT.
REQ-018 IDLE SHALL go to WAIT_FRM when run=1.
REQ-019 WAIT_FRM SHALL go to SWEEP on the cycle after cam_frame_done=1; cam_frame_done SHALL be sampled only in WAIT_FRM.
REQ-020 SWEEP SHALL emit proc_addr 0..C_IMG_COLS*C_IMG_ROWS-1, one per cycle, with proc_en=1, proc_col wrapping at C_IMG_COLS-1 and proc_row incrementing on that wrap.
REQ-021 After the last address (4799 by default), SWEEP SHALL go to DRAIN for exactly one cycle with proc_en=0.
REQ-022 cam_hold SHALL be 1 in SWEEP and DRAIN only.
REQ-023 The argmax SHALL sample hist_in from the cycle after the first SWEEP cycle through DRAIN, paired with proc_col delayed one cycle.
REQ-024 The argmax SHALL replace the stored maximum only on a strictly greater value, so the lowest column wins a tie; it SHALL clear on SWEEP entry.
REQ-025 On DRAIN exit, the block SHALL latch result_col and result_cnt, set result_found=(result_cnt>=C_MIN_HIST), and enter REPORT with result_valid=1.
REQ-026 Result outputs SHALL stay stable while result_valid=1 and result_ready=0.
REQ-027 In REPORT with result_ready=1, the block SHALL clear result_valid the next cycle and go to WAIT_FRM if run=1, else IDLE.
REQ-028 cam_frame_done in any state other than WAIT_FRM SHALL pulse frm_drop for one cycle and SHALL be otherwise ignored.
REQ-029 Deasserting run in SWEEP or DRAIN SHALL NOT abort the sweep; the result is still reported.
REQ-030 Deasserting run in WAIT_FRM SHALL return the FSM to IDLE the next cycle.

Reset
REQ-031 On rst=1, the block SHALL set the FSM to IDLE and force all outputs and counters to 0 immediately, independent of clk.
REQ-032 rst asserted mid-sweep SHALL discard the partial result, and result_valid SHALL NOT assert for that frame.

Configuration
REQ-033 With macro FRAME_WDOG_EN defined, a counter SHALL run in WAIT_FRM, clear on leaving it, and on reaching C_WDOG_CYC set wdog_err sticky (cleared only by rst) and return the FSM to IDLE.
REQ-034 Without FRAME_WDOG_EN, wdog_err SHALL be constant 0 and WAIT_FRM SHALL wait indefinitely.

Verification
REQ-035 The bench SHALL cover: run=1, frame_done pulse, hist_in peak 20 at col 37 -> result_col=37, result_cnt=20, result_found=1, result_valid 4802 cycles after the pulse.
REQ-036 The bench SHALL cover: equal peak 12 at cols 10 and 50 -> result_col=10.
REQ-037 The bench SHALL cover: max hist_in=3 -> result_found=0, result_cnt=3.
REQ-038 The bench SHALL cover: result_ready held 0 for 100 cycles, then a cam_frame_done pulse -> results stable, frm_drop=1 for one cycle, no new sweep.
REQ-039 The bench SHALL cover: rst pulse at address 2000 -> all outputs 0, IDLE, no result_valid.
REQ-040 The bench SHALL cover, with FRAME_WDOG_EN and C_WDOG_CYC=50: no frame for 50 cycles -> wdog_err=1 and FSM in IDLE.

Source files
------------

// File: rtl/frame_proc_ctrl.sv
// Frame processing controller: sweeps the frame buffer, tracks the peak column count
// and reports it with a ready/valid handshake. Optional WAIT_FRM watchdog: FRAME_WDOG_EN.
module frame_proc_ctrl #(
  parameter int unsigned C_IMG_COLS    = 80,
  parameter int unsigned C_IMG_ROWS    = 60,
  parameter int unsigned C_NB_IMG_PXLS = 13,
  parameter int unsigned C_MIN_HIST    = 4,
  parameter int unsigned C_WDOG_CYC    = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     cam_frame_done,
  output logic                     cam_hold,
  output logic [C_NB_IMG_PXLS-1:0] proc_addr,
  output logic [6:0]               proc_col,
  output logic [5:0]               proc_row,
  output logic                     proc_en,
  input  logic [5:0]               hist_in,
  output logic                     result_valid,
  output logic [6:0]               result_col,
  output logic [5:0]               result_cnt,
  output logic                     result_found,
  input  logic                     result_ready,
  output logic                     frm_drop,
  output logic                     wdog_err
);

  localparam int unsigned COL_W = 7;
  localparam int unsigned ROW_W = 6;
  localparam int unsigned CNT_W = 6;

  localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(C_IMG_COLS * C_IMG_ROWS - 1);
  localparam logic [COL_W-1:0]         LAST_COL  = COL_W'(C_IMG_COLS - 1);
  localparam logic [CNT_W-1:0]         MIN_HIST  = CNT_W'(C_MIN_HIST);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_FRM = 3'd1;
  localparam logic [2:0] S_SWEEP    = 3'd2;
  localparam logic [2:0] S_DRAIN    = 3'd3;
  localparam logic [2:0] S_REPORT   = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [C_NB_IMG_PXLS-1:0] addr_d;
  logic [COL_W-1:0]         col_d, dcol_q, dcol_d, max_col_q, max_col_d, col_nx_c;
  logic [ROW_W-1:0]         row_d;
  logic [CNT_W-1:0]         max_cnt_q, max_cnt_d, cnt_nx_c, res_cnt_d;
  logic [COL_W-1:0]         res_col_d;
  logic                     en_d, hold_d, samp_q, samp_d, gt_c;
  logic                     res_valid_d, res_found_d, frm_drop_d;

`ifdef FRAME_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(C_WDOG_CYC + 1);
  logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic              wdog_err_d;
`endif

  // Argmax candidate: hist_in belongs to the column addressed one cycle earlier
  assign gt_c     = samp_q && (hist_in > max_cnt_q);
  assign cnt_nx_c = gt_c ? hist_in : max_cnt_q;
  assign col_nx_c = gt_c ? dcol_q  : max_col_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = proc_addr;
    col_d       = proc_col;
    row_d       = proc_row;
    en_d        = 1'b0;
    hold_d      = 1'b0;
    samp_d      = proc_en;
    dcol_d      = proc_col;
    max_cnt_d   = cnt_nx_c;
    max_col_d   = col_nx_c;
    res_valid_d = result_valid;
    res_col_d   = result_col;
    res_cnt_d   = result_cnt;
    res_found_d = result_found;
    frm_drop_d  = cam_frame_done && (state_q != S_WAIT_FRM);
`ifdef FRAME_WDOG_EN
    wdog_cnt_d  = '0;
    wdog_err_d  = wdog_err;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_WAIT_FRM;
      end
      S_WAIT_FRM: begin
        if (cam_frame_done) begin
          state_d   = S_SWEEP;
          addr_d    = '0;
          col_d     = '0;
          row_d     = '0;
          en_d      = 1'b1;
          hold_d    = 1'b1;
          max_cnt_d = '0;
          max_col_d = '0;
        end else if (!run) begin
          state_d = S_IDLE;
        end else begin
`ifdef FRAME_WDOG_EN
          if (wdog_cnt_q == WDOG_W'(C_WDOG_CYC - 1)) begin
            wdog_err_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
          end
`endif
        end
      end
      S_SWEEP: begin
        hold_d = 1'b1;
        if (proc_addr == LAST_ADDR) begin
          state_d = S_DRAIN;
          addr_d  = '0;
          col_d   = '0;
          row_d   = '0;
        end else begin
          en_d   = 1'b1;
          addr_d = proc_addr + C_NB_IMG_PXLS'(1);
          if (proc_col == LAST_COL) begin
            col_d = '0;
            row_d = proc_row + ROW_W'(1);
          end else begin
            col_d = proc_col + COL_W'(1);
          end
        end
      end
      S_DRAIN: begin
        state_d     = S_REPORT;
        res_valid_d = 1'b1;
        res_col_d   = col_nx_c;
        res_cnt_d   = cnt_nx_c;
        res_found_d = (cnt_nx_c >= MIN_HIST);
      end
      S_REPORT: begin
        if (result_ready) begin
          res_valid_d = 1'b0;
          state_d     = run ? S_WAIT_FRM : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      proc_addr    <= '0;
      proc_col     <= '0;
      proc_row     <= '0;
      proc_en      <= 1'b0;
      cam_hold     <= 1'b0;
      samp_q       <= 1'b0;
      dcol_q       <= '0;
      max_cnt_q    <= '0;
      max_col_q    <= '0;
      result_valid <= 1'b0;
      result_col   <= '0;
      result_cnt   <= '0;
      result_found <= 1'b0;
      frm_drop     <= 1'b0;
    end else begin
      state_q      <= state_d;
      proc_addr    <= addr_d;
      proc_col     <= col_d;
      proc_row     <= row_d;
      proc_en      <= en_d;
      cam_hold     <= hold_d;
      samp_q       <= samp_d;
      dcol_q       <= dcol_d;
      max_cnt_q    <= max_cnt_d;
      max_col_q    <= max_col_d;
      result_valid <= res_valid_d;
      result_col   <= res_col_d;
      result_cnt   <= res_cnt_d;
      result_found <= res_found_d;
      frm_drop     <= frm_drop_d;
    end
  end

`ifdef FRAME_WDOG_EN
  // Watchdog error is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err   <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err   <= wdog_err_d;
    end
  end
`else
  assign wdog_err = 1'b0;
`endif

endmodule
